// File: rtl/dsram_bridge_pkg.sv
// Shared types for the memory-stage data port bridge: stage request structs,
// access size encodings, bus payload and FSM state.
package dsram_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned PERF_W = 32;

  localparam logic [SIZE_W-1:0] MSIZE_B = 2'd0;
  localparam logic [SIZE_W-1:0] MSIZE_H = 2'd1;
  localparam logic [SIZE_W-1:0] MSIZE_W = 2'd2;

  typedef struct packed {
    logic              ren;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
  } m_r_t;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] wdata;
  } m_w_t;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } dsram_state_t;

  // Write side wins when both are raised; reads carry no write data.
  function automatic bus_req_t decode_req(input m_r_t r, input m_w_t w);
    bus_req_t b;
    if (w.wen) begin
      b.wr    = 1'b1;
      b.size  = w.size;
      b.addr  = w.addr;
      b.wdata = w.wdata;
    end else begin
      b.wr    = 1'b0;
      b.size  = r.size;
      b.addr  = r.addr;
      b.wdata = '0;
    end
    return b;
  endfunction

endpackage

// File: rtl/dsram_bridge_perf.sv
// Saturating bus-accept and stall-cycle counters for dsram_bridge.
// Only compiled when DSRAM_BRIDGE_PERF_EN is defined.
`ifdef DSRAM_BRIDGE_PERF_EN
module dsram_bridge_perf
  import dsram_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              acc_inc,
  input  logic              wait_inc,
  output logic [PERF_W-1:0] perf_acc,
  output logic [PERF_W-1:0] perf_wait
);

  localparam logic [PERF_W-1:0] SAT = '1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_acc  <= '0;
      perf_wait <= '0;
    end else begin
      if (acc_inc && (perf_acc != SAT)) perf_acc <= perf_acc + PERF_W'(1);
      if (wait_inc && (perf_wait != SAT)) perf_wait <= perf_wait + PERF_W'(1);
    end
  end

endmodule
`endif

// File: rtl/dsram_bridge.sv
// Memory-stage data port to SRAM-like data bus bridge with hazard stall.
// Define DSRAM_BRIDGE_PERF_EN to add perf_acc/perf_wait counters.
module dsram_bridge
  import dsram_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  m_r_t              mread,
  input  m_w_t              mwrite,
  output logic [DATA_W-1:0] rd,
  output logic              d_stall,
  input  logic              stallM,
  input  logic              flushM,
  output logic              data_req,
  output logic              data_wr,
  output logic [SIZE_W-1:0] data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
`ifdef DSRAM_BRIDGE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_acc,
  output logic [PERF_W-1:0] perf_wait
`endif
);

  dsram_state_t      state, state_nxt;
  bus_req_t          req_cur, req_lat, req_lat_nxt, bus;
  logic              flush_pend, flush_pend_nxt, flush_any;
  logic              access, issue;
  logic [DATA_W-1:0] rd_nxt;

  // Issue is gated by resetn so the zero-cycle path also goes quiet in reset.
  assign access    = mread.ren | mwrite.wen;
  assign issue     = access & ~flushM & resetn;
  assign req_cur   = decode_req(mread, mwrite);
  assign flush_any = flush_pend | flushM;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      req_lat    <= '0;
      flush_pend <= 1'b0;
      rd         <= '0;
    end else begin
      state      <= state_nxt;
      req_lat    <= req_lat_nxt;
      flush_pend <= flush_pend_nxt;
      rd         <= rd_nxt;
    end
  end

  // A flushed transaction still drains to data_ok, then skips DONE.
  always_comb begin
    state_nxt      = state;
    req_lat_nxt    = req_lat;
    flush_pend_nxt = flush_pend;
    rd_nxt         = rd;
    bus            = '0;
    data_req       = 1'b0;
    d_stall        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue) begin
          data_req       = 1'b1;
          d_stall        = 1'b1;
          bus            = req_cur;
          req_lat_nxt    = req_cur;
          flush_pend_nxt = 1'b0;
          if (data_addr_ok && data_data_ok) begin
            state_nxt = ST_DONE;
            if (!req_cur.wr) rd_nxt = data_rdata;
          end else if (data_addr_ok) begin
            state_nxt = ST_DATA;
          end else begin
            state_nxt = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        data_req       = 1'b1;
        d_stall        = 1'b1;
        bus            = req_lat;
        flush_pend_nxt = flush_any;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            flush_pend_nxt = 1'b0;
            state_nxt      = flush_any ? ST_IDLE : ST_DONE;
            if (!flush_any && !req_lat.wr) rd_nxt = data_rdata;
          end else begin
            state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        d_stall        = 1'b1;
        flush_pend_nxt = flush_any;
        if (data_data_ok) begin
          flush_pend_nxt = 1'b0;
          state_nxt      = flush_any ? ST_IDLE : ST_DONE;
          if (!flush_any && !req_lat.wr) rd_nxt = data_rdata;
        end
      end
      ST_DONE: begin
        if (!stallM) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign data_wr    = bus.wr;
  assign data_size  = bus.size;
  assign data_addr  = bus.addr;
  assign data_wdata = bus.wdata;

`ifdef DSRAM_BRIDGE_PERF_EN
  dsram_bridge_perf u_perf (
    .clk      (clk),
    .resetn   (resetn),
    .acc_inc  (data_req & data_addr_ok),
    .wait_inc (d_stall),
    .perf_acc (perf_acc),
    .perf_wait(perf_wait)
  );
`endif

endmodule

// File: tb/tb_dsram_bridge.sv
// Scoreboard bench for dsram_bridge: transaction driver pushes expectations,
// a negedge monitor pops and compares against bus/stall/rd behaviour.
module tb_dsram_bridge;
  import dsram_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  m_r_t        mread;
  m_w_t        mwrite;
  logic [31:0] rd;
  logic        d_stall;
  logic        stallM;
  logic        flushM;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
`ifdef DSRAM_BRIDGE_PERF_EN
  logic [31:0] perf_acc;
  logic [31:0] perf_wait;
`endif

  dsram_bridge dut (
    .clk         (clk),
    .resetn      (resetn),
    .mread       (mread),
    .mwrite      (mwrite),
    .rd          (rd),
    .d_stall     (d_stall),
    .stallM      (stallM),
    .flushM      (flushM),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata)
`ifdef DSRAM_BRIDGE_PERF_EN
    ,
    .perf_acc    (perf_acc),
    .perf_wait   (perf_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          req_cycles;
  } exp_bus_t;

  exp_bus_t    bus_q[$];
  logic [31:0] rd_q[$];
  int          stall_q[$];
  logic [31:0] rd_model;
  logic        expect_idle;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic missing(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: DUT event with no expectation queued at %0t", name, $time);
  endtask

  // Monitor: handshake-driven pops from the expectation queues.
  int       req_cnt;
  int       stall_cnt;
  bit       rd_pending;
  exp_bus_t mon_e;

  always @(negedge clk) begin
    if (!resetn) begin
      req_cnt    = 0;
      stall_cnt  = 0;
      rd_pending = 0;
    end else begin
      assert (!(mread.ren && mwrite.wen)) else $error("ren and wen raised together");
      if (rd_pending) begin
        rd_pending = 0;
        if (rd_q.size() == 0) missing("rd");
        else check("rd", rd, rd_q.pop_front());
      end
      if (expect_idle) begin
        check("idle_req", 32'(data_req), 32'd0);
        check("idle_stall", 32'(d_stall), 32'd0);
        check("rd_hold", rd, rd_model);
      end
      if (data_req) req_cnt++;
      if (d_stall) stall_cnt++;
      if (data_req && data_addr_ok) begin
        if (bus_q.size() == 0) missing("addr_hs");
        else begin
          mon_e = bus_q.pop_front();
          check("bus_wr", 32'(data_wr), 32'(mon_e.wr));
          check("bus_addr", data_addr, mon_e.addr);
          check("bus_size", 32'(data_size), 32'(mon_e.size));
          if (mon_e.wr) check("bus_wdata", data_wdata, mon_e.wdata);
          check("req_cycles", 32'(req_cnt), 32'(mon_e.req_cycles));
        end
        req_cnt = 0;
      end
      if (d_stall && data_data_ok) begin
        if (stall_q.size() == 0) missing("data_hs");
        else check("stall_cycles", 32'(stall_cnt), 32'(stall_q.pop_front()));
        stall_cnt  = 0;
        rd_pending = 1;
      end
    end
  end

  // One access: addr_ok after a cycles, data_ok d cycles later, optional
  // flush at cycle fk (0 = none), then hold cycles in DONE with stallM=1.
  task automatic run_tx(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int a, input int d, input int fk, input int hold);
    m_r_t     r;
    m_w_t     w;
    exp_bus_t e;
    if (wr) begin
      w = '{wen: 1'b1, addr: addr, size: size, wdata: wdata};
      r = '{ren: 1'b0, addr: $urandom, size: 2'($urandom)};
    end else begin
      r = '{ren: 1'b1, addr: addr, size: size};
      w = '{wen: 1'b0, addr: $urandom, size: 2'($urandom), wdata: $urandom};
    end
    e.wr = wr; e.addr = addr; e.size = size; e.wdata = wdata; e.req_cycles = a + 1;
    bus_q.push_back(e);
    if (!wr && fk == 0) rd_model = rdata;
    rd_q.push_back(rd_model);
    stall_q.push_back(a + d + 1);
    for (int k = 0; k <= a + d; k++) begin
      if (fk != 0 && k > fk) begin
        mread  = '0;
        mwrite = '0;
      end else begin
        mread  = r;
        mwrite = w;
      end
      flushM       = (fk != 0 && k == fk);
      data_addr_ok = (k == a);
      data_data_ok = (k == a + d);
      data_rdata   = (k == a + d) ? rdata : $urandom;
      stallM       = 1'($urandom);
      expect_idle  = 1'b0;
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    flushM       = 1'b0;
    stallM       = 1'b0;
    if (fk == 0) begin
      for (int j = 0; j <= hold; j++) begin
        expect_idle = 1'b1;
        stallM      = (j < hold);
        @(posedge clk); #1;
      end
    end
    mread       = '0;
    mwrite      = '0;
    stallM      = 1'b0;
    expect_idle = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      expect_idle = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  // A request presented together with flushM must never reach the bus.
  task automatic idle_flush();
    mread       = '{ren: 1'b1, addr: $urandom, size: MSIZE_W};
    flushM      = 1'b1;
    expect_idle = 1'b1;
    @(posedge clk); #1;
    flushM = 1'b0;
    mread  = '0;
  endtask

  task automatic rand_tx();
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    int          a, d, fk;
    wr   = 1'($urandom);
    size = 2'($urandom_range(0, 2));
    addr = $urandom;
    if (size == MSIZE_H) addr[0] = 1'b0;
    if (size == MSIZE_W) addr[1:0] = 2'b00;
    a  = $urandom_range(0, 3);
    d  = $urandom_range(0, 3);
    fk = 0;
    if ((a + d) >= 1 && $urandom_range(0, 3) == 0) fk = $urandom_range(1, a + d);
    run_tx(wr, addr, size, $urandom, $urandom, a, d, fk, $urandom_range(0, 2));
    if ($urandom_range(0, 5) == 0) idle_flush();
    idle_cycles($urandom_range(0, 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(data_req), 32'd0);
    check({tag, "_stall"}, 32'(d_stall), 32'd0);
    check({tag, "_rd"}, rd, 32'd0);
    check({tag, "_addr"}, data_addr, 32'd0);
    check({tag, "_wr"}, 32'(data_wr), 32'd0);
    check({tag, "_size"}, 32'(data_size), 32'd0);
    check({tag, "_wdata"}, data_wdata, 32'd0);
  endtask

  task automatic reset_mid_addr();
    mread        = '{ren: 1'b1, addr: 32'h0000_0200, size: MSIZE_W};
    mwrite       = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    expect_idle  = 1'b0;
    @(posedge clk); #1;
    check("mid_addr_req", 32'(data_req), 32'd1);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("mid_rst");
    bus_q.delete();
    rd_q.delete();
    stall_q.delete();
    rd_model = '0;
    mread    = '0;
    @(posedge clk);
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    expect_idle = 1'b1;
  endtask

  initial begin
    resetn       = 1'b0;
    mread        = '0;
    mwrite       = '0;
    stallM       = 1'b0;
    flushM       = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    expect_idle  = 1'b0;
    rd_model     = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    expect_idle = 1'b1;

    run_tx(1'b0, 32'h8000_0010, MSIZE_W, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0);
    run_tx(1'b1, 32'h0000_0100, MSIZE_W, 32'h1234_5678, 32'hFFFF_0000, 2, 3, 0, 0);
`ifdef DSRAM_BRIDGE_PERF_EN
    check("perf_acc", perf_acc, 32'd2);
    check("perf_wait", perf_wait, 32'd7);
`endif
    run_tx(1'b0, 32'h8000_0044, MSIZE_W, 32'h0, 32'hCAFE_F00D, 1, 1, 0, 4);
    run_tx(1'b0, 32'h8000_0080, MSIZE_H, 32'h0, 32'h5555_AAAA, 1, 3, 2, 0);
    run_tx(1'b0, 32'h8000_0091, MSIZE_B, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, 1);
    idle_flush();
    idle_cycles(2);

    for (int i = 0; i < 300; i++) rand_tx();
    reset_mid_addr();
    for (int i = 0; i < 20; i++) rand_tx();
    idle_cycles(3);

    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("stall_q_drained", 32'(stall_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
